// File: rtl/uart_rx_ctrl.sv
// UART receiver control stage: start detection, edge/bit counting,
// phase sequencing, checker enables and the per-frame result pulse.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic       data_valid,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [3:0] LastData = 4'(DATA_WIDTH);

    state_e     state_q;
    logic [5:0] edge_q;
    logic [5:0] edge_d;
    logic [3:0] bit_q;
    logic [3:0] bit_d;
    logic       par_q;
    logic       valid_q;
    logic       ferr_q;

    logic [5:0] edge_last;
    logic [5:0] deser_pt;
    logic       bit_end;
    logic       frame_bad;

    assign edge_last = Prescale - 6'd1;
    assign deser_pt  = (Prescale >> 1) + 6'd3;
    assign bit_end   = (edge_q == edge_last);
    // A stale parity error must not reject a frame sent without parity.
    assign frame_bad = stp_err | (PAR_EN & par_q);

    always_comb begin
        edge_d = edge_q + 6'd1;
        bit_d  = bit_q;
        if (state_q == IDLE) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (bit_end) begin
            edge_d = '0;
            bit_d  = bit_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!RX_IN) state_q <= START;
                end
                START: begin
                    if (bit_end) begin
                        if (strt_glitch) begin
                            state_q <= IDLE;
                            edge_q  <= '0;
                            bit_q   <= '0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_end && bit_q == LastData) begin
                        state_q <= PAR_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_q   <= par_err;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                        edge_q  <= '0;
                        bit_q   <= '0;
                        par_q   <= 1'b0;
                        valid_q <= ~frame_bad;
                        ferr_q  <= frame_bad;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign dat_samp_en = (state_q != IDLE);
    assign strt_chk_en = (state_q == START);
    assign par_chk_en  = (state_q == PARITY);
    assign stp_chk_en  = (state_q == STOP);
    assign deser_en    = (state_q == DATA) && (edge_q == deser_pt);
    assign data_valid  = valid_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames plus randomized frames,
// every cycle compared against a frame-position reference model.
module tb_uart_rx_ctrl;

    localparam int DW = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       deser_en;
    logic       data_valid;
    logic       frame_err;

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .PAR_EN(PAR_EN),
        .Prescale(Prescale),
        .strt_glitch(strt_glitch),
        .par_err(par_err),
        .stp_err(stp_err),
        .edge_cnt(edge_cnt),
        .bit_cnt(bit_cnt),
        .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en),
        .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en),
        .deser_en(deser_en),
        .data_valid(data_valid),
        .frame_err(frame_err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;

    // Reference model: k is the cycle offset from the first START cycle,
    // or -1 when idle; everything else follows from k and Prescale.
    int k = -1;
    bit par_lat = 1'b0;
    bit e_valid = 1'b0;
    bit e_ferr = 1'b0;

    int deser_q[$];
    int valid_q[$];
    int ferr_q[$];
    int n_par = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 idle, 1 start, 2 data, 3 parity, 4 stop
    function automatic int phase_of(input int b, input bit pen);
        if (b == 0) return 1;
        if (b <= DW) return 2;
        if (pen && b == DW + 1) return 3;
        return 4;
    endfunction

    task automatic cycle_check();
        int p;
        int ee;
        int eb;
        int ph;
        p = int'(Prescale);
        if (k < 0) begin
            ee = 0;
            eb = 0;
            ph = 0;
        end else begin
            ee = k % p;
            eb = k / p;
            ph = phase_of(eb, PAR_EN);
        end
        chk("edge_cnt", 32'(edge_cnt), 32'(ee));
        chk("bit_cnt", 32'(bit_cnt), 32'(eb));
        chk("dat_samp_en", 32'(dat_samp_en), 32'(ph != 0));
        chk("strt_chk_en", 32'(strt_chk_en), 32'(ph == 1));
        chk("par_chk_en", 32'(par_chk_en), 32'(ph == 3));
        chk("stp_chk_en", 32'(stp_chk_en), 32'(ph == 4));
        chk("deser_en", 32'(deser_en), 32'(ph == 2 && ee == p / 2 + 3));
        chk("data_valid", 32'(data_valid), 32'(e_valid));
        chk("frame_err", 32'(frame_err), 32'(e_ferr));
    endtask

    task automatic model_adv();
        int p;
        int ph;
        bit be;
        bit err;
        bit nv;
        bit nf;
        p = int'(Prescale);
        nv = 1'b0;
        nf = 1'b0;
        if (!RST) begin
            k = -1;
            par_lat = 1'b0;
        end else if (k < 0) begin
            if (!RX_IN) k = 0;
        end else begin
            be = (k % p == p - 1);
            ph = phase_of(k / p, PAR_EN);
            if (be && ph == 1 && strt_glitch) begin
                k = -1;
            end else if (be && ph == 4) begin
                err = stp_err | (PAR_EN & par_lat);
                nf = err;
                nv = !err;
                par_lat = 1'b0;
                k = -1;
            end else begin
                if (be && ph == 3) par_lat = par_err;
                k++;
            end
        end
        e_valid = nv;
        e_ferr = nf;
    endtask

    task automatic tick();
        cycle_check();
        if (deser_en === 1'b1) deser_q.push_back(cyc - start_cyc);
        if (par_chk_en === 1'b1) n_par++;
        if (data_valid === 1'b1) valid_q.push_back(cyc);
        if (frame_err === 1'b1) ferr_q.push_back(cyc);
        model_adv();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run_frame(input int p, input bit pen, input logic [7:0] d,
                             input bit gl, input bit pe, input bit se,
                             input int rst_k, input bit b2b, input bit noisy);
        int nb;
        int len;
        int b;
        int e;
        nb = DW + 2 + int'(pen);
        len = gl ? p : nb * p;
        Prescale = 6'(p);
        PAR_EN = pen;
        RST = 1'b1;
        RX_IN = 1'b0;
        strt_glitch = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b0;
        deser_q.delete();
        n_par = 0;
        start_cyc = cyc + 1;
        tick();
        for (int kk = 0; kk < len; kk++) begin
            b = kk / p;
            e = kk % p;
            if (b == 0) RX_IN = 1'b0;
            else if (b <= DW) RX_IN = d[b-1];
            else if (pen && b == DW + 1) RX_IN = ^d;
            else RX_IN = 1'b1;
            if (noisy) RX_IN = 1'($urandom_range(0, 1));
            if (b == 0 && e == p - 1) strt_glitch = gl;
            else strt_glitch = noisy && b == 0 && $urandom_range(0, 1) == 1;
            if (pen && b == DW + 1 && e == p - 1) par_err = pe;
            else par_err = noisy && $urandom_range(0, 1) == 1;
            if (b == nb - 1 && e >= p / 2 + 3) stp_err = se;
            else stp_err = noisy && $urandom_range(0, 1) == 1;
            RST = (kk != rst_k);
            tick();
            if (kk == rst_k) break;
        end
        RST = 1'b1;
        strt_glitch = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b0;
        if (b2b) begin
            RX_IN = 1'b0;
        end else begin
            RX_IN = 1'b1;
            tick();
        end
    endtask

    initial begin
        int p;
        int rk;
        bit pen;
        bit bb;
        RST = 1'b0;
        RX_IN = 1'b1;
        PAR_EN = 1'b0;
        Prescale = 6'd8;
        strt_glitch = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b0;
        @(posedge CLK);
        #1;
        tick();
        RX_IN = 1'b0;
        tick();
        RST = 1'b1;
        RX_IN = 1'b1;
        tick();
        tick();

        valid_q.delete();
        ferr_q.delete();
        run_frame(8, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        chk("t1_deser_count", 32'(deser_q.size()), 32'd8);
        chk("t1_deser_first", 32'(deser_q.size() > 0 ? deser_q[0] : -1), 32'd15);
        chk("t1_deser_last", 32'(deser_q.size() > 7 ? deser_q[7] : -1), 32'd71);
        chk("t1_valid_count", 32'(valid_q.size()), 32'd1);
        chk("t1_valid_cycle",
            32'(valid_q.size() > 0 ? valid_q[0] - start_cyc : -1), 32'd80);
        chk("t1_ferr_count", 32'(ferr_q.size()), 32'd0);

        valid_q.delete();
        ferr_q.delete();
        run_frame(16, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        chk("t2_par_cycles", 32'(n_par), 32'd16);
        chk("t2_ferr_count", 32'(ferr_q.size()), 32'd1);
        chk("t2_ferr_cycle",
            32'(ferr_q.size() > 0 ? ferr_q[0] - start_cyc : -1), 32'd176);
        chk("t2_valid_count", 32'(valid_q.size()), 32'd0);

        valid_q.delete();
        ferr_q.delete();
        run_frame(8, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        chk("t3_ferr_cycle",
            32'(ferr_q.size() > 0 ? ferr_q[0] - start_cyc : -1), 32'd80);
        chk("t3_valid_count", 32'(valid_q.size()), 32'd0);

        valid_q.delete();
        ferr_q.delete();
        run_frame(8, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        chk("t4_deser_count", 32'(deser_q.size()), 32'd0);
        chk("t4_pulse_count", 32'(valid_q.size() + ferr_q.size()), 32'd0);

        valid_q.delete();
        ferr_q.delete();
        run_frame(8, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 3 * 8 + 2, 1'b0, 1'b0);
        chk("t5_pulse_after_rst", 32'(valid_q.size() + ferr_q.size()), 32'd0);
        run_frame(8, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        chk("t5_valid_count", 32'(valid_q.size()), 32'd1);

        valid_q.delete();
        ferr_q.delete();
        run_frame(8, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        run_frame(8, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        chk("t6_valid_count", 32'(valid_q.size()), 32'd2);
        chk("t6_valid_gap",
            32'(valid_q.size() > 1 ? valid_q[1] - valid_q[0] : -1), 32'd81);

        bb = 1'b0;
        repeat (40) begin
            case ($urandom_range(0, 2))
                0: p = 8;
                1: p = 16;
                default: p = 32;
            endcase
            pen = 1'($urandom_range(0, 1));
            rk = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 10 * p)) : -1;
            if (!bb) begin
                repeat ($urandom_range(0, 3)) tick();
            end
            bb = ($urandom_range(0, 2) == 0);
            run_frame(p, pen, 8'($urandom),
                      $urandom_range(0, 4) == 0,
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0,
                      rk, bb, 1'b1);
        end
        RX_IN = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Control stage of the UART receiver. Detects the start edge on RX_IN and runs the per-bit edge counter and bit counter. Sequences the START/DATA/PARITY/STOP phases and drives the enables of the sampler, start checker, parity checker, stop checker and deserializer. Consumes the checker error flags (including stp_err) and issues a one-cycle data_valid or frame_err pulse per frame.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (supported range 5..8)

Ports:
CLK  input  1  clock
RST  input  1  reset; synchronous, active-low
RX_IN  input  1  serial line, idle high
PAR_EN  input  1  1 = frame carries a parity bit
Prescale  input  6  oversampling ratio; legal values 8, 16, 32
strt_glitch  input  1  start checker error, registered
par_err  input  1  parity checker error, registered
stp_err  input  1  stop checker error, registered
edge_cnt  output  6  edge index within current bit, 0..Prescale-1
bit_cnt  output  4  bit index within frame (0 = start)
dat_samp_en  output  1  sampler enable
strt_chk_en  output  1  start checker enable
par_chk_en  output  1  parity checker enable
stp_chk_en  output  1  stop checker enable
deser_en  output  1  deserializer shift strobe
data_valid  output  1  one-cycle pulse: frame accepted
frame_err  output  1  one-cycle pulse: frame rejected

Behaviour:
- Reset (RST=0 at a CLK edge) forces state IDLE, edge_cnt=0, bit_cnt=0, data_valid=0, frame_err=0 and the internal par_err latch to 0. All enables go to 0. Reset mid-frame abandons the frame with no pulse.
- States: IDLE, START, DATA, PARITY, STOP. Enables are decoded from the state (Moore). All enables are 0 in IDLE.
- IDLE: edge_cnt=0, bit_cnt=0. If RX_IN=0 the next state is START. The first START cycle has edge_cnt=0.
- Counters, in every non-IDLE state:
  - edge_cnt increments by 1 each cycle.
  - At edge_cnt==Prescale-1, edge_cnt wraps to 0 and bit_cnt increments.
  - The "bit end" cycle is the cycle with edge_cnt==Prescale-1.
- START (bit_cnt=0):
  - dat_samp_en=1, strt_chk_en=1.
  - At bit end: if strt_glitch=1, go to IDLE (no pulse, counters cleared); otherwise go to DATA.
- DATA (bit_cnt 1..DATA_WIDTH):
  - dat_samp_en=1.
  - deser_en=1 for exactly one cycle per bit, when edge_cnt==(Prescale>>1)+3. This is computed in 6-bit arithmetic; for Prescale=8 it equals 7.
  - At the bit end of bit_cnt==DATA_WIDTH: go to PARITY if PAR_EN=1, else STOP.
- PARITY:
  - dat_samp_en=1, par_chk_en=1.
  - At bit end, latch par_err into the internal latch and go to STOP.
- STOP:
  - dat_samp_en=1, stp_chk_en=1.
  - The stop checker samples at edge_cnt==(Prescale>>1)+2, so stp_err is valid from the next cycle.
  - At bit end go to IDLE and clear the counters. On the next cycle:
    - if stp_err=1 or the par_err latch is 1: frame_err=1, data_valid=0;
    - otherwise: data_valid=1.
  - The par_err latch clears at the same edge that asserts the pulse.
- data_valid and frame_err are never both 1. Each pulse lasts exactly 1 cycle.
- Back-to-back frames:
  - The pulse cycle is an IDLE cycle, and RX_IN=0 seen there starts the next frame.
  - RX_IN is ignored outside IDLE.
- The par_err latch is used only when PAR_EN=1. With PAR_EN=0, the par_err input is ignored.
- Prescale and PAR_EN must be stable outside IDLE. Behaviour for other values is undefined.

Test Plan:
1. Prescale=8, PAR_EN=0, frame 0 / 0x55 / 1, checkers clean:
   - START entered at cycle 0;
   - deser_en pulses at cycles 15, 23, …, 71 (8 pulses);
   - stp_chk_en high in cycles 72..79;
   - data_valid=1 at cycle 80 only; frame_err stays 0.
2. Prescale=16, PAR_EN=1, par_err=1 driven at parity bit end, stp_err=0:
   - par_chk_en high for exactly 16 cycles;
   - frame_err=1 exactly one cycle after stop bit end; data_valid stays 0.
3. Prescale=8, stp_err=1 asserted from stop edge 7:
   - frame_err pulse at cycle 80; state IDLE at cycle 80.
4. strt_glitch=1 at START bit end (edge 7):
   - return to IDLE at cycle 8;
   - no deser_en, data_valid or frame_err asserted;
   - edge_cnt=0, bit_cnt=0.
5. RST=0 held one cycle at DATA bit 3:
   - next cycle IDLE, all outputs 0;
   - a subsequent clean frame produces data_valid normally.
6. Two back-to-back frames, second start bit driven low during the first frame's pulse cycle:
   - two data_valid pulses 81 cycles apart (Prescale=8, PAR_EN=0).
